// File: rtl/inst_fetch_buf_pkg.sv
// Shared definitions for the instruction fetch buffer: reset PC default,
// front-end state encoding and the credit counter width helper.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef enum logic {
        BOOT,
        RUN
    } fetch_state_e;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/inst_fetch_buf_fifo.sv
// Prefetch FIFO: synchronous push/pop with a flush, zero-latency head data.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        push,
    input  logic [DATA_W-1:0]           push_data,
    input  logic                        pop,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic [DATA_W-1:0]           head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    always_comb begin
        do_push  = push && !clear && (count_q != CNT_W'(DEPTH));
        do_pop   = pop && !clear && (count_q != '0);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        count = count_q;
        head  = mem_q[rd_ptr_q];
    end

endmodule

// File: rtl/inst_fetch_buf.sv
// Instruction fetch front end: credit-limited request generator over a
// gnt/fin memory handshake, prefetch FIFO toward IF/ID, redirect flush.
module inst_fetch_buf
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              id_stall,
    output logic              read_ce,
    output logic [ADDR_W-3:0] irom_addr,
    input  logic              irom_gnt,
    input  logic              irom_fin,
    input  logic [DATA_W-1:0] rom_inst,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              stall_pc_flush_if_id
);

    localparam int unsigned CNT_W = cnt_width(DEPTH);
    localparam int unsigned SUM_W = CNT_W + 2;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] head_pc_q, head_pc_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] head_data;
    logic [SUM_W-1:0]  in_use;
    logic              grant, push, pop;
    logic              unused_pc_bits;

    fetch_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (redirect),
        .push      (push),
        .push_data (rom_inst),
        .pop       (pop),
        .count     (count),
        .head      (head_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        case (state_q)
            BOOT:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        in_use               = SUM_W'(outst_q) + SUM_W'(count) + SUM_W'(drop_q);
        read_ce              = (state_q == RUN) && !redirect && (in_use < SUM_W'(DEPTH));
        irom_addr            = fetch_pc_q[ADDR_W-1:2];
        inst_valid           = (count != '0);
        inst                 = head_data;
        inst_pc              = head_pc_q;
        stall_pc_flush_if_id = !inst_valid;
        unused_pc_bits       = ^redirect_pc[1:0];
    end

    always_comb begin
        grant      = read_ce && irom_gnt;
        pop        = inst_valid && !id_stall && !redirect;
        push       = 1'b0;
        fetch_pc_d = fetch_pc_q;
        head_pc_d  = head_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        if (redirect) begin
            fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
            head_pc_d  = {redirect_pc[ADDR_W-1:2], 2'b00};
            // Live requests become stale: fold them into drop so that outst
            // only ever counts responses that will be kept.
            drop_d     = drop_q + outst_q
                       - CNT_W'(irom_fin && ((drop_q != '0) || (outst_q != '0)));
            outst_d    = '0;
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(4);
            end
            if (pop) begin
                head_pc_d = head_pc_q + ADDR_W'(4);
            end
            if (irom_fin && (drop_q != '0)) begin
                drop_d = drop_q - 1'b1;
            end else if (irom_fin && (outst_q != '0)) begin
                push = 1'b1;
            end
            outst_d = outst_q + CNT_W'(grant) - CNT_W'(push);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            head_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_pc_q  <= head_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Directed bench for inst_fetch_buf with a pipelined in-order memory model.
module tb_inst_fetch_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        read_ce;
    logic [29:0] irom_addr;
    logic        irom_gnt;
    logic        irom_fin = 1'b0;
    logic [31:0] rom_inst = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        stall_pc_flush_if_id;

    int          n_checks = 0;
    int          n_pass   = 0;
    int unsigned lat      = 1;
    int unsigned cyc      = 0;
    logic [31:0] exp_pc;

    typedef struct {
        logic [29:0] waddr;
        int unsigned due;
    } req_t;
    req_t pending[$];

    always #5 clk = ~clk;

    inst_fetch_buf #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .DEPTH    (4),
        .RESET_PC (32'hBFC0_0000)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .redirect             (redirect),
        .redirect_pc          (redirect_pc),
        .id_stall             (id_stall),
        .read_ce              (read_ce),
        .irom_addr            (irom_addr),
        .irom_gnt             (irom_gnt),
        .irom_fin             (irom_fin),
        .rom_inst             (rom_inst),
        .inst_valid           (inst_valid),
        .inst                 (inst),
        .inst_pc              (inst_pc),
        .stall_pc_flush_if_id (stall_pc_flush_if_id)
    );

    function automatic logic [31:0] word_data(input logic [29:0] waddr);
        return {waddr, 2'b10} ^ 32'h3C5A_0000;
    endfunction

    // Memory: accepts every granted request, answers in order 'lat' cycles on.
    always @(posedge clk) begin
        if (!rst_n) begin
            pending.delete();
        end else begin
            if (irom_fin) begin
                if (pending.size() == 0)
                    $error("FAIL mem_protocol fin with nothing pending");
                else
                    void'(pending.pop_front());
            end
            if (read_ce && irom_gnt)
                pending.push_back('{waddr: irom_addr, due: cyc + lat - 1});
        end
        #1;
        if (pending.size() != 0 && pending[0].due <= cyc) begin
            irom_fin = 1'b1;
            rom_inst = word_data(pending[0].waddr);
        end else begin
            irom_fin = 1'b0;
            rom_inst = '0;
        end
        cyc++;
    end

    task automatic pop_one(output logic [31:0] pc, output logic [31:0] data, output bit ok);
        ok       = 1'b0;
        pc       = '0;
        data     = '0;
        id_stall = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (inst_valid) begin
                pc   = inst_pc;
                data = inst;
                ok   = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; id_stall = 1'b0; irom_gnt = 1'b1; lat = 1;
        repeat (2) @(negedge clk);
        n_checks++; if (read_ce !== 1'b0) $display("FAIL rst_read_ce got %0h want 0", read_ce); else n_pass++;
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL rst_inst_valid got %0h want 0", inst_valid); else n_pass++;
        n_checks++; if (stall_pc_flush_if_id !== 1'b1) $display("FAIL rst_stall got %0h want 1", stall_pc_flush_if_id); else n_pass++;
        n_checks++; if (inst !== 32'h0) $display("FAIL rst_inst got %h want 0", inst); else n_pass++;
        n_checks++; if (irom_addr !== 30'h2FF0_0000) $display("FAIL rst_irom_addr got %h want 2ff00000", irom_addr); else n_pass++;
        rst_n = 1'b1;
        #1;
        n_checks++; if (read_ce !== 1'b0) $display("FAIL boot_read_ce got %0h want 0", read_ce); else n_pass++;
        @(negedge clk);
        n_checks++; if (read_ce !== 1'b1) $display("FAIL run_read_ce got %0h want 1", read_ce); else n_pass++;
        n_checks++; if (irom_addr !== 30'h2FF0_0000) $display("FAIL run_irom_addr got %h want 2ff00000", irom_addr); else n_pass++;
    endtask

    task automatic test_stream();
        logic [31:0] pc;
        @(negedge clk);
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL stream_latency got %0h want 0", inst_valid); else n_pass++;
        @(negedge clk);
        pc = 32'hBFC0_0000;
        for (int k = 0; k < 6; k++) begin
            n_checks++; if (inst_valid !== 1'b1) $display("FAIL stream_valid[%0d] got %0h want 1", k, inst_valid); else n_pass++;
            n_checks++; if (inst_pc !== pc) $display("FAIL stream_pc[%0d] got %h want %h", k, inst_pc, pc); else n_pass++;
            n_checks++; if (inst !== word_data(pc[31:2])) $display("FAIL stream_inst[%0d] got %h want %h", k, inst, word_data(pc[31:2])); else n_pass++;
            pc = pc + 32'd4;
            @(negedge clk);
        end
        exp_pc = pc;
    endtask

    task automatic test_stall();
        id_stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (inst_pc !== exp_pc) $display("FAIL stall_pc[%0d] got %h want %h", i, inst_pc, exp_pc); else n_pass++;
            n_checks++; if (inst !== word_data(exp_pc[31:2])) $display("FAIL stall_inst[%0d] got %h want %h", i, inst, word_data(exp_pc[31:2])); else n_pass++;
            @(negedge clk);
        end
        n_checks++; if (read_ce !== 1'b0) $display("FAIL stall_full_read_ce got %0h want 0", read_ce); else n_pass++;
        n_checks++; if (stall_pc_flush_if_id !== 1'b0) $display("FAIL stall_flush got %0h want 0", stall_pc_flush_if_id); else n_pass++;
        n_checks++; if (pending.size() !== 0) $display("FAIL stall_pending got %0d want 0", pending.size()); else n_pass++;
        id_stall = 1'b0;
        for (int k = 0; k < 6; k++) begin
            n_checks++; if (inst_valid !== 1'b1) $display("FAIL release_valid[%0d] got %0h want 1", k, inst_valid); else n_pass++;
            n_checks++; if (inst_pc !== exp_pc) $display("FAIL release_pc[%0d] got %h want %h", k, inst_pc, exp_pc); else n_pass++;
            exp_pc = exp_pc + 32'd4;
            @(negedge clk);
        end
    endtask

    task automatic test_latency();
        int max_pend = 0;
        int got = 0;
        lat = 3;
        for (int i = 0; i < 60; i++) begin
            id_stall = (i >= 20 && i < 30);
            if (pending.size() > max_pend) max_pend = pending.size();
            if (inst_valid && !id_stall) begin
                n_checks++; if (inst_pc !== exp_pc) $display("FAIL lat_pc got %h want %h", inst_pc, exp_pc); else n_pass++;
                n_checks++; if (inst !== word_data(exp_pc[31:2])) $display("FAIL lat_inst got %h want %h", inst, word_data(exp_pc[31:2])); else n_pass++;
                exp_pc = exp_pc + 32'd4;
                got++;
            end
            if (i == 29) begin
                n_checks++; if (read_ce !== 1'b0) $display("FAIL lat_full_read_ce got %0h want 0", read_ce); else n_pass++;
            end
            @(negedge clk);
        end
        id_stall = 1'b0;
        n_checks++; if (max_pend > 4 || max_pend < 3) $display("FAIL lat_outstanding got %0d want 3..4", max_pend); else n_pass++;
        n_checks++; if (got < 30) $display("FAIL lat_progress got %0d want >=30", got); else n_pass++;
    endtask

    task automatic test_redirect();
        logic [31:0] pc, d;
        bit ok;
        bit found = 1'b0;
        lat = 2;
        id_stall = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (pending.size() == 2 && irom_fin) begin
                found = 1'b1;
            end else begin
                if (inst_valid) begin
                    n_checks++; if (inst_pc !== exp_pc) $display("FAIL redir_pre_pc got %h want %h", inst_pc, exp_pc); else n_pass++;
                    exp_pc = exp_pc + 32'd4;
                end
                @(negedge clk);
            end
        end
        n_checks++; if (found !== 1'b1) $display("FAIL redir_setup got %0h want 1", found); else n_pass++;
        redirect = 1'b1; redirect_pc = 32'h0000_1003;
        #1;
        n_checks++; if (read_ce !== 1'b0) $display("FAIL redir_read_ce got %0h want 0", read_ce); else n_pass++;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL redir_flushed got %0h want 0", inst_valid); else n_pass++;
        n_checks++; if (read_ce !== 1'b1) $display("FAIL redir_reissue got %0h want 1", read_ce); else n_pass++;
        n_checks++; if (irom_addr !== 30'h400) $display("FAIL redir_addr got %h want 400", irom_addr); else n_pass++;
        pop_one(pc, d, ok);
        n_checks++; if (!ok || pc !== 32'h1000) $display("FAIL redir_pc0 got %h want 00001000", pc); else n_pass++;
        n_checks++; if (d !== word_data(30'h400)) $display("FAIL redir_inst0 got %h want %h", d, word_data(30'h400)); else n_pass++;
        pop_one(pc, d, ok);
        n_checks++; if (!ok || pc !== 32'h1004) $display("FAIL redir_pc1 got %h want 00001004", pc); else n_pass++;
        n_checks++; if (d !== word_data(30'h401)) $display("FAIL redir_inst1 got %h want %h", d, word_data(30'h401)); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] pc, d;
        bit ok;
        redirect = 1'b1; redirect_pc = 32'h0000_2000;
        @(negedge clk);
        redirect_pc = 32'h0000_3000;
        #1;
        n_checks++; if (read_ce !== 1'b0) $display("FAIL b2b_read_ce got %0h want 0", read_ce); else n_pass++;
        @(negedge clk);
        redirect = 1'b0;
        pop_one(pc, d, ok);
        n_checks++; if (!ok || pc !== 32'h3000) $display("FAIL b2b_pc0 got %h want 00003000", pc); else n_pass++;
        n_checks++; if (d !== word_data(30'hC00)) $display("FAIL b2b_inst0 got %h want %h", d, word_data(30'hC00)); else n_pass++;
        pop_one(pc, d, ok);
        n_checks++; if (!ok || pc !== 32'h3004) $display("FAIL b2b_pc1 got %h want 00003004", pc); else n_pass++;
        n_checks++; if (d !== word_data(30'hC01)) $display("FAIL b2b_inst1 got %h want %h", d, word_data(30'hC01)); else n_pass++;
    endtask

    task automatic test_gnt_hold();
        logic [31:0] pc, d;
        bit ok;
        irom_gnt = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h0000_5000;
        @(negedge clk);
        redirect = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (read_ce !== 1'b1) $display("FAIL hold_read_ce[%0d] got %0h want 1", i, read_ce); else n_pass++;
            n_checks++; if (irom_addr !== 30'h1400) $display("FAIL hold_addr[%0d] got %h want 1400", i, irom_addr); else n_pass++;
            @(negedge clk);
        end
        irom_gnt = 1'b1;
        pop_one(pc, d, ok);
        n_checks++; if (!ok || pc !== 32'h5000) $display("FAIL hold_pc0 got %h want 00005000", pc); else n_pass++;
        n_checks++; if (d !== word_data(30'h1400)) $display("FAIL hold_inst0 got %h want %h", d, word_data(30'h1400)); else n_pass++;
        pop_one(pc, d, ok);
        n_checks++; if (!ok || pc !== 32'h5004) $display("FAIL hold_pc1 got %h want 00005004", pc); else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] pc, d;
        bit ok;
        bit found = 1'b0;
        lat = 3;
        for (int i = 0; i < 40 && !found; i++) begin
            if (pending.size() == 3) found = 1'b1;
            else @(negedge clk);
        end
        n_checks++; if (found !== 1'b1) $display("FAIL mid_setup got %0h want 1", found); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (read_ce !== 1'b0) $display("FAIL mid_rst_read_ce got %0h want 0", read_ce); else n_pass++;
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL mid_rst_valid got %0h want 0", inst_valid); else n_pass++;
        n_checks++; if (stall_pc_flush_if_id !== 1'b1) $display("FAIL mid_rst_stall got %0h want 1", stall_pc_flush_if_id); else n_pass++;
        n_checks++; if (inst !== 32'h0) $display("FAIL mid_rst_inst got %h want 0", inst); else n_pass++;
        n_checks++; if (irom_addr !== 30'h2FF0_0000) $display("FAIL mid_rst_addr got %h want 2ff00000", irom_addr); else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (read_ce !== 1'b0) $display("FAIL mid_boot_read_ce got %0h want 0", read_ce); else n_pass++;
        pop_one(pc, d, ok);
        n_checks++; if (!ok || pc !== 32'hBFC0_0000) $display("FAIL mid_pc0 got %h want bfc00000", pc); else n_pass++;
        n_checks++; if (d !== word_data(30'h2FF0_0000)) $display("FAIL mid_inst0 got %h want %h", d, word_data(30'h2FF0_0000)); else n_pass++;
        pop_one(pc, d, ok);
        n_checks++; if (!ok || pc !== 32'hBFC0_0004) $display("FAIL mid_pc1 got %h want bfc00004", pc); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_latency();
        test_redirect();
        test_back_to_back();
        test_gnt_hold();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
